// File: rtl/div_8by4.sv
// Iterative 8-by-4 restoring divider: one quotient bit per clock, valid/ready on both sides.
// Define DIV_ZERO_DETECT_EN to short-circuit divide-by-zero to DONE with dbz=1.
module div_8by4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       dbz
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] dvd_q, dvd_d;
  logic [7:0] quo_q, quo_d;
  logic [3:0] dvs_q, dvs_d;
  logic [3:0] rem_q, rem_d;
  logic [4:0] r5, diff;
  logic       qbit;
`ifdef DIV_ZERO_DETECT_EN
  logic       dbz_q, dbz_d;
`endif

  always_comb begin
    r5      = {rem_q, dvd_q[7]};
    diff    = r5 - {1'b0, dvs_q};
    qbit    = (r5 >= {1'b0, dvs_q});
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef DIV_ZERO_DETECT_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        dvd_d   = dividend;
        dvs_d   = divisor;
        cnt_d   = 3'd0;
        rem_d   = 4'd0;
        quo_d   = 8'd0;
        state_d = RUN;
`ifdef DIV_ZERO_DETECT_EN
        dbz_d   = 1'b0;
        if (divisor == 4'd0) begin
          quo_d   = 8'hFF;
          dbz_d   = 1'b1;
          state_d = DONE;
        end
`endif
      end
      RUN: begin
        // Without zero detect, divisor 0 always subtracts nothing: q=FF, r=dividend[3:0].
        dvd_d = {dvd_q[6:0], 1'b0};
        quo_d = {quo_q[6:0], qbit};
        rem_d = qbit ? diff[3:0] : r5[3:0];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      dvd_q   <= 8'd0;
      dvs_q   <= 4'd0;
      quo_q   <= 8'd0;
      rem_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbz_q <= 1'b0;
    else        dbz_q <= dbz_d;
  end
  assign dbz = dbz_q;
`else
  assign dbz = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_div_8by4.sv
// Scoreboard bench for div_8by4: expected results queued at accept, checked when out_valid rises.
module tb_div_8by4;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       out_valid;
  logic       out_ready;
  logic       dbz;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    logic [4:0] lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errs    = 0;

  div_8by4 dut (
    .clk(clk), .rst_n(rst_n), .dividend(dividend), .divisor(divisor),
    .in_valid(in_valid), .in_ready(in_ready), .quotient(quotient),
    .remainder(remainder), .out_valid(out_valid), .out_ready(out_ready), .dbz(dbz)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    if (b != 4'd0) begin
      e.q = a / {4'd0, b};
      e.r = 4'(a % {4'd0, b});
      e.z = 1'b0;
      e.lat = 5'd8;
    end else begin
      e.q = 8'hFF;
`ifdef DIV_ZERO_DETECT_EN
      e.r = 4'h0;
      e.z = 1'b1;
      e.lat = 5'd0;
`else
      e.r = a[3:0];
      e.z = 1'b0;
      e.lat = 5'd8;
`endif
    end
    return e;
  endfunction

  // Drive one accept; leaves the bench 1ns after the accept edge.
  task automatic accept(input logic [7:0] a, input logic [3:0] b);
    int n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges counted after the accept edge until out_valid is seen; 31 on timeout.
  task automatic wait_valid(output logic [4:0] lat);
    int n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    lat = out_valid ? 5'(n) : 5'd31;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = 8'd0; divisor = 4'd0;
    #1;
    vectors++;
    if ({in_ready, out_valid, dbz, quotient, remainder} !== {1'b1, 1'b0, 1'b0, 8'd0, 4'd0}) begin
      $display("FAIL reset_async got rdy=%b vld=%b dbz=%b q=%0d r=%0d required 1 0 0 0 0",
               in_ready, out_valid, dbz, quotient, remainder);
      errs++;
    end
    in_valid = 1'b1; dividend = 8'd77; divisor = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, out_valid, quotient} !== {1'b1, 1'b0, 8'd0}) begin
      $display("FAIL reset_held got rdy=%b vld=%b q=%0d required 1 0 0", in_ready, out_valid, quotient);
      errs++;
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e; logic [4:0] lat;
    out_ready = 1'b1;
    sb.push_back(model(8'd200, 4'd7));
    accept(8'd200, 4'd7);
    wait_valid(lat);
    e = sb.pop_front();
    vectors++;
    if ({quotient, remainder, dbz, lat} !== {8'd28, 4'd4, 1'b0, 5'd8} || {e.q, e.r} !== {8'd28, 4'd4}) begin
      $display("FAIL basic_200_7 got q=%0d r=%0d dbz=%b lat=%0d required q=28 r=4 dbz=0 lat=8",
               quotient, remainder, dbz, lat);
      errs++;
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL basic_one_cycle got vld=%b rdy=%b required 0 1", out_valid, in_ready);
      errs++;
    end
  endtask

  task automatic test_sweep();
    exp_t e; logic [4:0] lat;
    out_ready = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        sb.push_back(model(8'(a), 4'(b)));
        accept(8'(a), 4'(b));
        wait_valid(lat);
        e = sb.pop_front();
        vectors++;
        if ({quotient, remainder, dbz, lat} !== {e.q, e.r, e.z, e.lat}) begin
          $display("FAIL sweep %0d/%0d got q=%0d r=%0d dbz=%b lat=%0d required q=%0d r=%0d dbz=%b lat=%0d",
                   a, b, quotient, remainder, dbz, lat, e.q, e.r, e.z, e.lat);
          errs++;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e; logic [4:0] lat;
    out_ready = 1'b0;
    sb.push_back(model(8'd100, 4'd3));
    accept(8'd100, 4'd3);
    wait_valid(lat);
    e = sb.pop_front();
    dividend = 8'd50; divisor = 4'd5; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({out_valid, in_ready, quotient, remainder} !== {1'b1, 1'b0, e.q, e.r} || e.q !== 8'd33) begin
        $display("FAIL backpressure_hold cyc%0d got vld=%b rdy=%b q=%0d r=%0d required 1 0 33 1",
                 i, out_valid, in_ready, quotient, remainder);
        errs++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL backpressure_release got vld=%b rdy=%b required 0 1", out_valid, in_ready);
      errs++;
    end
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL backpressure_ignored_in got vld=%b rdy=%b required 0 1", out_valid, in_ready);
      errs++;
    end
  endtask

  task automatic test_div_zero();
    exp_t e; logic [4:0] lat;
    out_ready = 1'b1;
    sb.push_back(model(8'hA7, 4'd0));
    accept(8'hA7, 4'd0);
    wait_valid(lat);
    e = sb.pop_front();
    vectors++;
`ifdef DIV_ZERO_DETECT_EN
    if ({quotient, remainder, dbz, lat} !== {8'hFF, 4'h0, 1'b1, 5'd0}) begin
      $display("FAIL dbz_A7 got q=%h r=%h dbz=%b lat=%0d required q=ff r=0 dbz=1 lat=0",
                quotient, remainder, dbz, lat);
      errs++;
    end
`else
    if ({quotient, remainder, dbz, lat} !== {8'hFF, 4'h7, 1'b0, 5'd8}) begin
      $display("FAIL dbz_A7 got q=%h r=%h dbz=%b lat=%0d required q=ff r=7 dbz=0 lat=8",
                quotient, remainder, dbz, lat);
      errs++;
    end
`endif
    if (e.q !== quotient) errs = errs;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    exp_t e; logic [4:0] lat;
    out_ready = 1'b1;
    accept(8'd50, 4'd5);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, dbz, quotient, remainder} !== {1'b1, 1'b0, 1'b0, 8'd0, 4'd0}) begin
      $display("FAIL abort_async got rdy=%b vld=%b dbz=%b q=%0d r=%0d required 1 0 0 0 0",
               in_ready, out_valid, dbz, quotient, remainder);
      errs++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL abort_no_result got vld=%b rdy=%b required 0 1", out_valid, in_ready);
      errs++;
    end
    sb.push_back(model(8'd9, 4'd2));
    accept(8'd9, 4'd2);
    wait_valid(lat);
    e = sb.pop_front();
    vectors++;
    if ({quotient, remainder, lat} !== {e.q, e.r, e.lat} || {e.q, e.r} !== {8'd4, 4'd1}) begin
      $display("FAIL abort_next_9_2 got q=%0d r=%0d lat=%0d required q=4 r=1 lat=8",
               quotient, remainder, lat);
      errs++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_div_zero();
    test_reset_abort();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
